wb_stage: RTL and testbench

Write-back stage of the five-stage MIPS pipeline, directly downstream of the MEM/WB pipeline register. It does four things:
- selects the write-back value and commits it to the 32×32 register file, which has two read ports for decode;
- executes `syscall` (halt on `$v0 == 10`, otherwise latch `$a0` to the display register);
- runs the RUN/HALT state machine the top level uses to freeze the pipeline;
- optionally maintains performance counters.

---
 rtl/wb_stage.sv | 180 ++++++++++++++++++
 tb/tb_wb_stage.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MIPS write-back stage: register file commit, syscall, RUN/HALT control
//
// Purpose: selects the write-back value, commits it to the 32x32 register file
// (two combinational read ports with write-through bypass), executes syscall
// (halt on $v0 == HALT_CODE, else latch $a0 to LED_data) and runs the RUN/HALT
// state machine used by the top level to freeze the pipeline.
// Optional feature macro: WB_STATS_EN (Cycle_cnt / Retire_cnt performance counters).
//
// Ports:
//   clk, clr                       clock, synchronous active-high reset
//   go                             resume pulse (honoured only in HALT)
//   Enable_in                      WB slot valid
//   Memtoreg_in, Regwrite_in,
//   Syscall_in, Jal_in             MEM/WB control
//   Order_in                       instruction word (0 = bubble)
//   PC_plus_4_in, ALU_Result1_in,
//   RD_in                          write-back candidates
//   Write_Reg_in                   destination register
//   R1_addr/R1_data, R2_addr/R2_data  decode read ports
//   WB_data                        selected write-back value (forwarding)
//   halt                           high in HALT
//   LED_data                       display register
//   Cycle_cnt, Retire_cnt          performance counters (0 without WB_STATS_EN)
module wb_stage #(
  parameter logic [31:0] HALT_CODE = 32'd10
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        go,
  input  logic        Enable_in,
  input  logic        Memtoreg_in,
  input  logic        Regwrite_in,
  input  logic        Syscall_in,
  input  logic        Jal_in,
  input  logic [31:0] Order_in,
  input  logic [31:0] PC_plus_4_in,
  input  logic [31:0] ALU_Result1_in,
  input  logic [31:0] RD_in,
  input  logic [4:0]  Write_Reg_in,
  input  logic [4:0]  R1_addr,
  input  logic [4:0]  R2_addr,
  output logic [31:0] R1_data,
  output logic [31:0] R2_data,
  output logic [31:0] WB_data,
  output logic        halt,
  output logic [31:0] LED_data,
  output logic [31:0] Cycle_cnt,
  output logic [31:0] Retire_cnt
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  state_e      state_q;
  logic        halt_q;
  logic [31:0] led_q;
  logic [31:0] regs_q [32];

  logic [4:0]  dest;
  logic        commit;
  logic        reg_we;
  logic [31:0] v0_val;
  logic [31:0] a0_val;

  // Write-back select: JAL link beats memory load beats ALU result.
  always_comb begin
    WB_data = ALU_Result1_in;
    if (Jal_in) begin
      WB_data = PC_plus_4_in;
    end else if (Memtoreg_in) begin
      WB_data = RD_in;
    end
  end

  assign dest   = Jal_in ? 5'd31 : Write_Reg_in;
  assign commit = Enable_in & (state_q == S_RUN) & ~clr;
  assign reg_we = commit & Regwrite_in & (dest != 5'd0);

  // Syscall operands come from storage, i.e. the pre-edge values, so a
  // syscall that also writes $v0/$a0 still acts on the old contents.
  assign v0_val = regs_q[2];
  assign a0_val = regs_q[4];

  // Read ports: r0 is hard zero; a same-cycle write to the addressed register
  // is forwarded so decode sees it without waiting for the edge.
  always_comb begin
    R1_data = regs_q[R1_addr];
    if (R1_addr == 5'd0) begin
      R1_data = '0;
    end else if (reg_we && (R1_addr == dest)) begin
      R1_data = WB_data;
    end
  end

  always_comb begin
    R2_data = regs_q[R2_addr];
    if (R2_addr == 5'd0) begin
      R2_data = '0;
    end else if (reg_we && (R2_addr == dest)) begin
      R2_data = WB_data;
    end
  end

  // Register file storage.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (reg_we) begin
      regs_q[dest] <= WB_data;
    end
  end

  // RUN/HALT state machine with registered halt and display outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_RUN;
      halt_q  <= 1'b0;
      led_q   <= '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (commit && Syscall_in) begin
            if (v0_val == HALT_CODE) begin
              state_q <= S_HALT;
              halt_q  <= 1'b1;
            end else begin
              led_q <= a0_val;
            end
          end
        end
        S_HALT: begin
          if (go) begin
            state_q <= S_RUN;
            halt_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_RUN;
          halt_q  <= 1'b0;
        end
      endcase
    end
  end

  assign halt     = halt_q;
  assign LED_data = led_q;

`ifdef WB_STATS_EN
  logic [31:0] cycle_q;
  logic [31:0] retire_q;

  // Both counters freeze in HALT; the halting syscall itself retires in RUN.
  always_ff @(posedge clk) begin
    if (clr) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else if (state_q == S_RUN) begin
      cycle_q <= cycle_q + 32'd1;
      if (commit && (Order_in != 32'd0)) begin
        retire_q <= retire_q + 32'd1;
      end
    end
  end

  assign Cycle_cnt  = cycle_q;
  assign Retire_cnt = retire_q;
`else
  // Order_in only feeds the retire counter.
  logic unused_order;
  assign unused_order = |Order_in;

  assign Cycle_cnt  = '0;
  assign Retire_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage
module tb_wb_stage;

`ifdef WB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int K_R1    = 0;
  localparam int K_R2    = 1;
  localparam int K_R1NOW = 2;
  localparam int K_WB    = 3;
  localparam int K_HALT  = 4;
  localparam int K_LED   = 5;
  localparam int K_CYC   = 6;
  localparam int K_RET   = 7;

  logic        clk = 1'b0;
  logic        clr;
  logic        go;
  logic        Enable_in;
  logic        Memtoreg_in;
  logic        Regwrite_in;
  logic        Syscall_in;
  logic        Jal_in;
  logic [31:0] Order_in;
  logic [31:0] PC_plus_4_in;
  logic [31:0] ALU_Result1_in;
  logic [31:0] RD_in;
  logic [4:0]  Write_Reg_in;
  logic [4:0]  R1_addr;
  logic [4:0]  R2_addr;
  logic [31:0] R1_data;
  logic [31:0] R2_data;
  logic [31:0] WB_data;
  logic        halt;
  logic [31:0] LED_data;
  logic [31:0] Cycle_cnt;
  logic [31:0] Retire_cnt;

  typedef struct {
    int          kind;
    logic [4:0]  addr;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  wb_stage #(.HALT_CODE(32'd10)) dut (
    .clk           (clk),
    .clr           (clr),
    .go            (go),
    .Enable_in     (Enable_in),
    .Memtoreg_in   (Memtoreg_in),
    .Regwrite_in   (Regwrite_in),
    .Syscall_in    (Syscall_in),
    .Jal_in        (Jal_in),
    .Order_in      (Order_in),
    .PC_plus_4_in  (PC_plus_4_in),
    .ALU_Result1_in(ALU_Result1_in),
    .RD_in         (RD_in),
    .Write_Reg_in  (Write_Reg_in),
    .R1_addr       (R1_addr),
    .R2_addr       (R2_addr),
    .R1_data       (R1_data),
    .R2_data       (R2_data),
    .WB_data       (WB_data),
    .halt          (halt),
    .LED_data      (LED_data),
    .Cycle_cnt     (Cycle_cnt),
    .Retire_cnt    (Retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic en, input logic m2r, input logic rw, input logic sc,
                       input logic jal, input logic [31:0] order, input logic [31:0] pc4,
                       input logic [31:0] alu, input logic [31:0] rd, input logic [4:0] wreg);
    Enable_in      = en;
    Memtoreg_in    = m2r;
    Regwrite_in    = rw;
    Syscall_in     = sc;
    Jal_in         = jal;
    Order_in       = order;
    PC_plus_4_in   = pc4;
    ALU_Result1_in = alu;
    RD_in          = rd;
    Write_Reg_in   = wreg;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
  endtask

  // One active edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op_write(input logic [4:0] r, input logic [31:0] v);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1, 32'h0, v, 32'h0, r);
    tick();
    idle();
  endtask

  task automatic op_syscall();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_000C, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    idle();
  endtask

  task automatic expect_val(input int kind, input logic [4:0] addr, input logic [31:0] exp,
                            input string tag);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.exp  = exp;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_R1:    begin R1_addr = e.addr; #1; obs = R1_data; end
        K_R2:    begin R2_addr = e.addr; #1; obs = R2_data; end
        K_R1NOW: obs = R1_data;
        K_WB:    obs = WB_data;
        K_HALT:  obs = {31'b0, halt};
        K_LED:   obs = LED_data;
        K_CYC:   obs = Cycle_cnt;
        default: obs = Retire_cnt;
      endcase
      check(e.tag, obs, e.exp);
    end
  endtask

  initial begin
    clr     = 1'b1;
    go      = 1'b0;
    R1_addr = 5'd0;
    R2_addr = 5'd0;
    idle();

    // Reset
    tick();
    clr = 1'b0;
    expect_val(K_HALT, 5'd0, 32'h0, "rst_halt");
    expect_val(K_LED, 5'd0, 32'h0, "rst_led");
    expect_val(K_CYC, 5'd0, 32'h0, "rst_cycle");
    expect_val(K_RET, 5'd0, 32'h0, "rst_retire");
    expect_val(K_R1, 5'd5, 32'h0, "rst_r5");
    expect_val(K_R2, 5'd31, 32'h0, "rst_r31");
    drain();

    // Write r5 with same-cycle bypass
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1, 32'h0, 32'h1234, 32'h0, 5'd5);
    R1_addr = 5'd5;
    #1;
    expect_val(K_R1NOW, 5'd5, 32'h1234, "bypass_r5");
    expect_val(K_WB, 5'd0, 32'h1234, "wb_alu");
    drain();
    tick();
    idle();
    expect_val(K_R1, 5'd5, 32'h1234, "stored_r5");
    drain();

    // Write to r0 is dropped
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1, 32'h0, 32'h55, 32'h0, 5'd0);
    R1_addr = 5'd0;
    #1;
    expect_val(K_R1NOW, 5'd0, 32'h0, "bypass_r0");
    drain();
    tick();
    idle();
    expect_val(K_R2, 5'd0, 32'h0, "stored_r0");
    drain();

    // Memtoreg selects RD_in
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1, 32'h0, 32'h1111, 32'hDEADBEEF, 5'd5);
    #1;
    expect_val(K_WB, 5'd0, 32'hDEADBEEF, "wb_mem");
    drain();
    tick();
    idle();
    expect_val(K_R1, 5'd5, 32'hDEADBEEF, "mem_r5");
    drain();

    // Jal forces r31 and PC+4
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1, 32'h3004, 32'h99, 32'h77, 5'd7);
    #1;
    expect_val(K_WB, 5'd0, 32'h3004, "wb_jal");
    drain();
    tick();
    idle();
    expect_val(K_R1, 5'd31, 32'h3004, "jal_r31");
    expect_val(K_R2, 5'd7, 32'h0, "jal_r7");
    drain();

    // Jal outranks Memtoreg
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1, 32'h4008, 32'h99, 32'hBAD, 5'd7);
    tick();
    idle();
    expect_val(K_R1, 5'd31, 32'h4008, "jal_over_mem");
    drain();

    // Display syscall
    op_write(5'd2, 32'd34);
    op_write(5'd4, 32'hCAFE);
    op_syscall();
    expect_val(K_LED, 5'd0, 32'hCAFE, "led_cafe");
    expect_val(K_HALT, 5'd0, 32'h0, "no_halt");
    drain();

    // Syscall that also writes $a0 latches the pre-edge $a0
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1, 32'h0, 32'hBEEF, 32'h0, 5'd4);
    tick();
    idle();
    expect_val(K_LED, 5'd0, 32'hCAFE, "led_old_a0");
    expect_val(K_R1, 5'd4, 32'hBEEF, "sys_write_r4");
    drain();

    // Halt and resume
    op_write(5'd2, 32'd10);
    op_syscall();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1, 32'h0, 32'h88, 32'h0, 5'd8);
    expect_val(K_HALT, 5'd0, 32'h1, "halt_rise");
    expect_val(K_R2, 5'd8, 32'h0, "halted_nobypass");
    drain();
    tick();
    tick();
    expect_val(K_HALT, 5'd0, 32'h1, "halt_hold");
    expect_val(K_R2, 5'd8, 32'h0, "halted_r8");
    expect_val(K_LED, 5'd0, 32'hCAFE, "halted_led");
    drain();
    go = 1'b1;
    tick();
    go = 1'b0;
    expect_val(K_HALT, 5'd0, 32'h0, "halt_fall");
    expect_val(K_R1, 5'd8, 32'h88, "resume_bypass_r8");
    drain();
    tick();
    idle();
    expect_val(K_R2, 5'd8, 32'h88, "resume_r8");
    drain();

    // Counters: 10 RUN cycles, 6 retiring commits, 2 bubbles, 2 idle
    clr = 1'b1;
    tick();
    clr = 1'b0;
    op_write(5'd2, 32'd10);
    for (int i = 1; i <= 5; i++) begin
      op_write(5'd9, 32'(i));
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h5, 32'h0, 5'd10);
    tick();
    tick();
    idle();
    tick();
    tick();
    expect_val(K_CYC, 5'd0, STATS ? 32'd10 : 32'd0, "cycle_10");
    expect_val(K_RET, 5'd0, STATS ? 32'd6 : 32'd0, "retire_6");
    drain();

    op_syscall();
    tick();
    tick();
    tick();
    expect_val(K_HALT, 5'd0, 32'h1, "cnt_halted");
    expect_val(K_CYC, 5'd0, STATS ? 32'd11 : 32'd0, "cycle_hold");
    expect_val(K_RET, 5'd0, STATS ? 32'd7 : 32'd0, "retire_hold");
    drain();

    // Resume, then clr together with a halting syscall: clr wins
    go = 1'b1;
    tick();
    go = 1'b0;
    expect_val(K_HALT, 5'd0, 32'h0, "go_resume");
    drain();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_000C, 32'h0, 32'h0, 32'h0, 5'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    idle();
    expect_val(K_HALT, 5'd0, 32'h0, "clr_sys_halt");
    expect_val(K_CYC, 5'd0, 32'h0, "clr_cycle");
    expect_val(K_RET, 5'd0, 32'h0, "clr_retire");
    expect_val(K_LED, 5'd0, 32'h0, "clr_led");
    expect_val(K_R1, 5'd2, 32'h0, "clr_r2");
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
